// File: rtl/hashin_pkg.sv
// rtl/hashin_pkg.sv - shared types, constants and helpers for the hashin frame unpacker
package hashin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_NONCE,
        ST_OUT
    } state_t;

    localparam logic [63:0] HASHIN_HDR_WORD   = 64'h8000000000000280;
    localparam int          HASHIN_BODY_WORDS = 10;
    localparam int          HDR_BITS          = 640;

    // Converts between the native nonce order and the wire order in the header tail.
    function automatic logic [31:0] byteswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/hashin_unpack.sv
// rtl/hashin_unpack.sv - pops hashin frames and nonces, rebuilds the 640-bit header for the hash core
//
// Optional feature macro: HASHIN_NONCE_CHECK_EN (compare header nonce field with the popped nonce).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous abort, drops any partial frame
//   hashin_fifo_out_dout/empty hashin FIFO head word and empty flag (FWFT)
//   hashin_fifo_out_re         hashin FIFO pop
//   nonce_fifo_dout/empty      nonce FIFO head and empty flag (FWFT)
//   nonce_fifo_re              nonce FIFO pop
//   hdr_valid/hdr_ready        handshake towards the hash core
//   hdr_data                   reassembled header, word 1 of the frame in the top 64 bits
//   hdr_nonce                  nonce in native order
//   err_sync                   pulse per dropped non-header word
//   err_nonce                  pulse on nonce mismatch (feature builds only)
//   frame_cnt                  completed hdr_valid&hdr_ready handshakes
import hashin_pkg::*;

module hashin_unpack #(
    parameter logic [63:0] HDR_WORD   = HASHIN_HDR_WORD,
    parameter int          BODY_WORDS = HASHIN_BODY_WORDS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [63:0]         hashin_fifo_out_dout,
    input  logic                hashin_fifo_out_empty,
    output logic                hashin_fifo_out_re,
    input  logic [31:0]         nonce_fifo_dout,
    input  logic                nonce_fifo_empty,
    output logic                nonce_fifo_re,
    output logic                hdr_valid,
    input  logic                hdr_ready,
    output logic [HDR_BITS-1:0] hdr_data,
    output logic [31:0]         hdr_nonce,
    output logic                err_sync,
    output logic                err_nonce,
    output logic [31:0]         frame_cnt
);

    localparam int CNT_W = $clog2(BODY_WORDS + 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pops are decoded straight from the state and the empty flags so a
    // word is taken in the same cycle it is seen; flush suppresses them.
    always_comb begin
        state_nx           = state;
        hashin_fifo_out_re = 1'b0;
        nonce_fifo_re      = 1'b0;
        if (flush) begin
            state_nx = ST_HEAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_HEAD;
                end
                ST_HEAD: begin
                    if (!hashin_fifo_out_empty) begin
                        hashin_fifo_out_re = 1'b1;
                        if (hashin_fifo_out_dout == HDR_WORD) begin
                            state_nx = ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (!hashin_fifo_out_empty) begin
                        hashin_fifo_out_re = 1'b1;
                        if (cnt == CNT_W'(BODY_WORDS - 1)) begin
                            state_nx = ST_NONCE;
                        end
                    end
                end
                ST_NONCE: begin
                    if (!nonce_fifo_empty) begin
                        nonce_fifo_re = 1'b1;
                        state_nx      = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (hdr_valid && hdr_ready) begin
                        state_nx = ST_HEAD;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            hdr_data  <= '0;
            hdr_nonce <= '0;
            hdr_valid <= 1'b0;
            frame_cnt <= '0;
            err_sync  <= 1'b0;
        end else begin
            // The counter only lives inside BODY; any exit (including the
            // last pop and flush) returns it to zero.
            if (flush || state_nx != ST_BODY) begin
                cnt <= '0;
            end else if (state == ST_BODY && hashin_fifo_out_re) begin
                cnt <= cnt + 1'b1;
            end

            if (state == ST_BODY && hashin_fifo_out_re) begin
                hdr_data <= {hdr_data[HDR_BITS-65:0], hashin_fifo_out_dout};
            end

            if (nonce_fifo_re) begin
                hdr_nonce <= nonce_fifo_dout;
            end

            hdr_valid <= (state_nx == ST_OUT);

            if (!flush && state == ST_OUT && hdr_valid && hdr_ready) begin
                frame_cnt <= frame_cnt + 32'd1;
            end

            err_sync <= (state == ST_HEAD) && hashin_fifo_out_re
                        && (hashin_fifo_out_dout != HDR_WORD);
        end
    end

`ifdef HASHIN_NONCE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_nonce <= 1'b0;
        end else begin
            err_nonce <= nonce_fifo_re && (byteswap32(hdr_data[31:0]) != nonce_fifo_dout);
        end
    end
`else
    assign err_nonce = 1'b0;
`endif

endmodule
